// File: rtl/piradspi_miso_packer.sv
// Receive-path byte packer: little-endian bytes from the SPI engine into
// bus-width AXI4-Stream words, closing a word early on a command's last byte.
`timescale 1ns/1ps
module piradspi_miso_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_byte_valid,
  output logic                    s_byte_ready,
  input  logic [7:0]              s_byte_data,
  input  logic                    s_byte_last,
  input  logic                    flush,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  word_count
);

  localparam int N = DATA_WIDTH / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N - 1);

  // Lanes 0..lane set, everything above cleared.
  function automatic logic [N-1:0] keep_mask(input logic [IDX_W-1:0] lane);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (i <= int'(lane));
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] place_byte(input logic [7:0]       b,
                                                      input logic [IDX_W-1:0] lane);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(lane) == i) begin
        w[8*i +: 8] = b;
      end
    end
    return w;
  endfunction

  logic [DATA_WIDTH-1:0]  acc_p0;
  logic [IDX_W-1:0]       idx_p0;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic [N-1:0]           keep_p1;
  logic                   last_p1;
  logic                   vld_p1;
  logic [COUNT_WIDTH-1:0] count_p1;

  logic                  byte_ready;
  logic                  accept;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] merged;

  // Input handshake is blocked only by a stalled output word or a flush.
  assign byte_ready = (!vld_p1 || m_tready) && !flush;
  assign accept     = s_byte_valid && byte_ready;
  assign word_done  = accept && ((idx_p0 == LAST_LANE) || s_byte_last);
  // Lanes above idx in acc are always zero, so OR-merging is exact.
  assign merged     = acc_p0 | place_byte(s_byte_data, idx_p0);

  // Stage p0: accumulator and lane index
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_p0 <= '0;
      idx_p0 <= '0;
    end else if (flush) begin
      acc_p0 <= '0;
      idx_p0 <= '0;
    end else if (accept) begin
      if (word_done) begin
        acc_p0 <= '0;
        idx_p0 <= '0;
      end else begin
        acc_p0 <= merged;
        idx_p0 <= idx_p0 + IDX_W'(1);
      end
    end
  end

  // Stage p1: output word register and handoff counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      data_p1  <= '0;
      keep_p1  <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      count_p1 <= '0;
    end else if (word_done) begin
      data_p1  <= merged;
      keep_p1  <= keep_mask(idx_p0);
      last_p1  <= s_byte_last;
      vld_p1   <= 1'b1;
      count_p1 <= count_p1 + COUNT_WIDTH'(1);
    end else if (vld_p1 && m_tready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign s_byte_ready = byte_ready;
  assign m_tvalid     = vld_p1;
  assign m_tdata      = data_p1;
  assign m_tkeep      = keep_p1;
  assign m_tlast      = last_p1;
  assign busy         = (idx_p0 != '0);
  assign word_count   = count_p1;

endmodule
